// File: rtl/mux_scan_if.sv
// Signal bundle between the scan sequencer and its controller / the 16:1 mux.
interface mux_scan_if #(
  parameter int N_CH    = 16,
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 4
);
  logic               start;
  logic [N_CH-1:0]    mask;
  logic [DWELL_W-1:0] dwell;
  logic               mux_out;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic               done;
  logic               sample_valid;
  logic [SEL_W-1:0]   sample_ch;
  logic               sample_bit;
  logic [N_CH-1:0]    capture;

  modport master (
    input  start, mask, dwell, mux_out,
    output sel, busy, done, sample_valid, sample_ch, sample_bit, capture
  );

  modport slave (
    output start, mask, dwell, mux_out,
    input  sel, busy, done, sample_valid, sample_ch, sample_bit, capture
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps the mux select through the enabled channels in ascending order, waits
// a programmable settle time on each, and assembles the sampled bits.
module mux_scan_sequencer #(
  parameter int N_CH    = 16,
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_scan_if.master bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;

  localparam logic [N_CH-1:0] ONE = N_CH'(1);

  logic [1:0]         state;
  logic [N_CH-1:0]    mask_l;
  logic [DWELL_W-1:0] dwell_l;
  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   sample_ch_q;
  logic               busy_q;
  logic               done_q;
  logic               sample_valid_q;
  logic               sample_bit_q;
  logic [N_CH-1:0]    capture_q;
  logic [N_CH-1:0]    above;

  function automatic logic [SEL_W-1:0] lowest_set(input logic [N_CH-1:0] m);
    lowest_set = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i]) lowest_set = SEL_W'(i);
  endfunction

  // Enabled channels strictly above the current select; empty at the top channel.
  always_comb begin
    above = mask_l & ~(((ONE << sel_q) << 1) - ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mask_l         <= '0;
      dwell_l        <= '0;
      cnt            <= '0;
      sel_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_bit_q   <= 1'b0;
      capture_q      <= '0;
    end else begin
      done_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mask_l    <= bus.mask;
            dwell_l   <= bus.dwell;
            capture_q <= '0;
            if (|bus.mask) begin
              sel_q  <= lowest_set(bus.mask);
              cnt    <= bus.dwell;
              busy_q <= 1'b1;
              state  <= SETTLE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - DWELL_W'(1);
        end
        SAMPLE: begin
          capture_q[sel_q] <= bus.mux_out;
          sample_valid_q   <= 1'b1;
          sample_ch_q      <= sel_q;
          sample_bit_q     <= bus.mux_out;
          if (|above) begin
            sel_q <= lowest_set(above);
            cnt   <= dwell_l;
            state <= SETTLE;
          end else begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel          = sel_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_ch    = sample_ch_q;
  assign bus.sample_bit   = sample_bit_q;
  assign bus.capture      = capture_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a timing-formula reference model.
module tb_mux_scan_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_word;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mux_scan_if #(.N_CH(16), .SEL_W(4), .DWELL_W(4)) bus ();

  assign bus.mux_out = in_word[bus.sel];

  mux_scan_sequencer #(.N_CH(16), .SEL_W(4), .DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: a scan is described by its start edge, dwell and channel list.
  int          m_active = 0;
  int          m_e0, m_d, m_k;
  int          m_q[$];
  int          rel, per;
  logic [3:0]  m_sel  = '0;
  logic [15:0] m_cap  = '0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_sv   = 1'b0;
  logic [3:0]  m_sch  = '0;
  logic        m_sbit = 1'b0;

  // Observed DUT events for the directed checks.
  int          done_cnt = 0;
  int          sv_cnt   = 0;
  int          last_done_cyc = -1;
  logic [15:0] cap_at_done = '0;
  int          sv_cyc[$];
  int          sv_chq[$];
  logic        busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_active = 0;
        m_sel    = '0;
        m_cap    = '0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_sv     = 1'b0;
      end else begin
        if (bus.start && !m_busy) begin
          m_active = 1;
          m_e0     = cyc;
          m_d      = int'(bus.dwell);
          m_q.delete();
          for (int i = 0; i < 16; i++)
            if (bus.mask[i]) m_q.push_back(i);
          m_k   = m_q.size();
          m_cap = '0;
        end
        m_done = 1'b0;
        m_sv   = 1'b0;
        if (m_active != 0) begin
          rel    = cyc - m_e0;
          per    = m_d + 2;
          m_busy = (m_k > 0) && (rel < m_k * per);
          m_done = (rel == m_k * per);
          if (m_k > 0) begin
            if (rel > 0 && rel % per == 0 && rel / per <= m_k) begin
              m_sv   = 1'b1;
              m_sch  = 4'(m_q[rel / per - 1]);
              m_sbit = in_word[m_q[rel / per - 1]];
              m_cap[m_q[rel / per - 1]] = m_sbit;
            end
            m_sel = (rel < m_k * per) ? 4'(m_q[rel / per]) : 4'(m_q[m_k - 1]);
          end
        end
        #1;
        check("sel", bus.sel, m_sel);
        check("busy", bus.busy, m_busy);
        check("done", bus.done, m_done);
        check("sample_valid", bus.sample_valid, m_sv);
        check("capture", bus.capture, m_cap);
        if (m_sv) begin
          check("sample_ch", bus.sample_ch, m_sch);
          check("sample_bit", bus.sample_bit, m_sbit);
        end
        if (bus.done) begin
          done_cnt++;
          last_done_cyc = cyc;
          cap_at_done   = bus.capture;
        end
        if (bus.sample_valid) begin
          sv_cnt++;
          sv_cyc.push_back(cyc);
          sv_chq.push_back(int'(bus.sample_ch));
        end
        if (bus.busy) busy_seen = 1'b1;
      end
    end
  end

  task automatic pulse_start(input logic [15:0] m, input logic [3:0] dw, output int e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mask  = m;
    bus.dwell = dw;
    e = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_cnt - base, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"}, bus.sel, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_sample_valid"}, bus.sample_valid, 0);
    check({tag, "_sample_ch"}, bus.sample_ch, 0);
    check({tag, "_sample_bit"}, bus.sample_bit, 0);
    check({tag, "_capture"}, bus.capture, 0);
  endtask

  initial begin
    int e0, d0, s0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mask  = '0;
    bus.dwell = '0;
    in_word   = '0;
    #2;
    check_all_zero("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_done_cnt", done_cnt, 0);

    // Full sweep, dwell 0
    in_word = 16'hA5C3;
    sv_cyc.delete(); sv_chq.delete();
    d0 = done_cnt;
    pulse_start(16'hFFFF, 4'd0, e0);
    wait_done(d0, 60);
    check("sweep_done_at", last_done_cyc - e0, 32);
    check("sweep_capture", cap_at_done, 16'hA5C3);
    check("sweep_samples", sv_cyc.size(), 16);
    for (int i = 0; i < sv_cyc.size(); i++) begin
      check("sweep_sv_cyc", sv_cyc[i] - e0, 2 * (i + 1));
      check("sweep_sv_ch", sv_chq[i], i);
    end
    repeat (2) @(negedge clk);

    // Sparse mask, dwell 3
    in_word = 16'hFFFF;
    sv_cyc.delete(); sv_chq.delete();
    d0 = done_cnt;
    pulse_start(16'h8001, 4'd3, e0);
    wait_done(d0, 40);
    check("sparse_samples", sv_cyc.size(), 2);
    if (sv_cyc.size() == 2) begin
      check("sparse_sv0_at", sv_cyc[0] - e0, 5);
      check("sparse_sv1_at", sv_cyc[1] - e0, 10);
      check("sparse_ch0", sv_chq[0], 0);
      check("sparse_ch1", sv_chq[1], 15);
    end
    check("sparse_done_at", last_done_cyc - e0, 10);
    check("sparse_capture", cap_at_done, 16'h8001);
    repeat (2) @(negedge clk);

    // Start and mask changes during a scan are ignored
    in_word = 16'hA5C3;
    sv_cyc.delete(); sv_chq.delete();
    d0 = done_cnt;
    s0 = sv_cnt;
    pulse_start(16'h00F0, 4'd1, e0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.mask  = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(d0, 40);
    repeat (6) @(negedge clk);
    check("ign_done_count", done_cnt - d0, 1);
    check("ign_sample_count", sv_cnt - s0, 4);
    check("ign_done_at", last_done_cyc - e0, 12);
    check("ign_capture", cap_at_done, 16'h00C0);
    for (int i = 0; i < sv_chq.size(); i++)
      check("ign_sv_ch", sv_chq[i], 4 + i);

    // Empty mask
    busy_seen = 1'b0;
    d0 = done_cnt;
    s0 = sv_cnt;
    pulse_start(16'h0000, 4'd2, e0);
    wait_done(d0, 10);
    repeat (4) @(negedge clk);
    check("empty_done_at", last_done_cyc - e0, 0);
    check("empty_capture", cap_at_done, 16'h0000);
    check("empty_busy_seen", busy_seen, 0);
    check("empty_samples", sv_cnt - s0, 0);
    check("empty_done_count", done_cnt - d0, 1);

    // Abort with reset in the third settle cycle of a full sweep
    in_word = 16'hA5C3;
    d0 = done_cnt;
    pulse_start(16'hFFFF, 4'd2, e0);
    while (cyc < e0 + 2) @(negedge clk);
    check("abort_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    sv_cyc.delete(); sv_chq.delete();
    d0 = done_cnt;
    pulse_start(16'h0002, 4'd0, e0);
    wait_done(d0, 20);
    check("post_abort_done_at", last_done_cyc - e0, 2);
    check("post_abort_capture", cap_at_done, 16'h0002);
    check("post_abort_samples", sv_chq.size(), 1);
    if (sv_chq.size() == 1) check("post_abort_ch", sv_chq[0], 1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Scan controller that sits directly upstream of the 16:1 channel multiplexer. It drives the mux select, waits a programmable settle time, and samples the mux output for every channel enabled in a mask. Sampled bits are assembled into a 16-bit capture word and reported per channel. The block handles start/busy/done sequencing so software or a higher-level FSM can trigger a full channel sweep with one pulse.

## Interface

Parameters:
- N_CH, 16, number of mux channels (power of two)
- SEL_W, 4, select width, log2(N_CH)
- DWELL_W, 4, width of settle-cycle count

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  scan request, sampled when idle
- mask  in  N_CH  channels to scan (bit i = channel i), latched on accepted start
- dwell  in  DWELL_W  extra settle cycles per channel, latched on accepted start
- mux_out  in  1  output of downstream 16:1 mux
- sel  out  SEL_W  select to the mux, registered
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- sample_valid  out  1  one-cycle pulse per sampled channel
- sample_ch  out  SEL_W  channel of the current sample
- sample_bit  out  1  value sampled on sample_ch
- capture  out  N_CH  assembled capture word

## Operation

- States: IDLE, SETTLE, SAMPLE.
- IDLE: on start=1:
  - latch mask and dwell; clear capture to 0.
  - If latched mask != 0: sel <= lowest set channel, cnt <= dwell, busy <= 1, go SETTLE.
  - If mask == 0: done <= 1 for one cycle, busy stays 0, remain IDLE.
- SETTLE: if cnt == 0 go SAMPLE, else cnt <= cnt-1. sel is held constant.
- SAMPLE (one cycle):
  - capture[sel] <= mux_out; sample_valid <= 1; sample_ch <= sel; sample_bit <= mux_out.
  - If latched mask has a set bit above sel: sel <= next higher set channel, cnt <= dwell, go SETTLE.
  - Otherwise: busy <= 0, done <= 1, go IDLE.
- Channels are visited in ascending order only, no wrap-around. Unmasked capture bits read 0.
- start is ignored while busy. Changes to mask or dwell during a scan have no effect.
- sel holds its last value in IDLE.
- Reset (asynchronous, any state):
  - state IDLE; sel=0, busy=0, done=0, sample_valid=0, sample_ch=0, sample_bit=0, capture=0.
  - A scan interrupted by reset is aborted with no done pulse.

## Timing

- All outputs are registered. mux_out is treated as combinational from sel.
- Start accepted at edge E0. From then:
  - sel is valid and busy is high.
  - Each channel occupies dwell+2 cycles: dwell+1 in SETTLE and 1 in SAMPLE.
- With k enabled channels and dwell d:
  - done is high, and busy low, in the cycle after edge E0 + k·(d+2).
  - sample_valid for the j-th channel (j = 1..k) is high after edge E0 + j·(d+2).
- The final sample_valid and done assert in the same cycle. capture is final in that cycle.
- Mask = 0: done is high in the cycle after E0.
- A start in the same cycle as done is accepted, because the block is already IDLE. The new scan clears capture on that edge.
- mux_out must be stable from the edge that updates sel through the SAMPLE edge. dwell sets the margin.

## Test plan

- Reset: assert rst_n low mid-cycle -> all outputs 0 immediately. Hold low, release -> block stays IDLE until start.
- Full sweep: mask=16'hFFFF, dwell=0, mux model with in=16'hA5C3, pulse start -> 16 sample_valid pulses, sample_ch 0..15 every 2 cycles. done and capture=16'hA5C3 32 cycles after E0.
- Sparse mask: mask=16'h8001, dwell=3, in=16'hFFFF -> sel goes 0 then 15. Two samples at E0+5 and E0+10, done at E0+10, capture=16'h8001.
- Ignored inputs: during a 16'h00F0 scan, pulse start and change mask to 16'hFFFF -> only channels 4–7 sampled, exactly one done.
- Empty mask: mask=0, start -> busy never high, done one cycle after E0, capture=0, no sample_valid.
- Abort: assert rst_n low at the 3rd SETTLE cycle of a full sweep -> outputs reset, no done. After release, a new start with mask=16'h0002 gives capture=in[1] at position 1.
